fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the pipelined core. It replaces the bare PC register and the single-entry instruction-memory hookup. It drives the synchronous instruction memory, which has a registered address and one-cycle read latency. Fetched words land in a DEPTH-entry prefetch queue that feeds decode through a valid/ready handshake. Branch redirects flush the queue and discard in-flight data, and misaligned targets are flagged and halt fetching.

## Interface
- XLEN, 32: data/PC width.
- DEPTH, 4: prefetch queue entries; power of two, ≥ 2.
- ADDR_WIDTH, 8: instruction-memory word-address width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- imem_address  out  ADDR_WIDTH  word address, pc[ADDR_WIDTH+1:2].
- imem_read  out  1  fetch issued this cycle.
- imem_data  in  XLEN  memory word; valid the cycle after the issue.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  new PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head (low = stall).
- out_instruction  out  XLEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_misaligned  out  1  head is a misaligned-target marker.

## Operation
- **State**
  - fetch_pc.
  - State machine RUN/HALT.
  - Queue: head, tail, count.
  - In-flight register: valid, pc, misaligned.
- **Issue address**
  - next_pc = redirect_valid ? redirect_pc : fetch_pc.
  - imem_address = next_pc[ADDR_WIDTH+1:2], combinational.
- **Issue condition**
  - imem_read = 1 when the state is RUN, or when redirect_valid = 1.
  - It also requires count + inflight − pop < DEPTH, where pop = out_valid & out_ready.
  - With redirect_valid = 1, the condition uses count = 0 and inflight = 0, because the flush applies first.
  - On issue: fetch_pc ← next_pc + 4, modulo 2^XLEN, wrapping at the top of the address space.
  - Also on issue: in-flight ← {1, next_pc, next_pc[1:0] ≠ 0}.
  - With no issue: in-flight valid ← 0.
- **Push**
  - When in-flight is valid and was not flushed, write {imem_data, in-flight pc, in-flight misaligned} at tail.
- **Pop**
  - When out_valid & out_ready, advance head.
  - Push and pop in the same cycle keep count unchanged.
- **Redirect**, which has priority over everything:
  - Clear count, head and tail.
  - Drop the in-flight word so it never enters the queue.
  - Ignore any pop that cycle.
  - Enter RUN, then issue at redirect_pc in the same cycle, subject to the issue condition.
- **Misalignment**
  - An issue with next_pc[1:0] ≠ 0 moves the state machine RUN → HALT.
  - That entry is enqueued with misaligned = 1; its instruction is the truncated-address word, and decode must trap.
  - No further issue happens until a redirect.
  - HALT → RUN only on redirect_valid.
- **Output**
  - out_* reflect the head entry when count > 0.
  - out_instruction, out_pc and out_misaligned are 0 when out_valid = 0.
- Overflow is impossible by the issue credit rule; pop on empty is ignored.

## Timing
- **Reset values**
  - out_valid, out_instruction, out_pc, out_misaligned = 0.
  - fetch_pc = RESET_PC; state = RUN; queue empty; in-flight invalid.
  - imem_read = 1 and imem_address = RESET_PC[ADDR_WIDTH+1:2] combinationally once reset deasserts.
- **Latency**
  - Issue at cycle N → imem_data at N+1 → pushed at the end of N+1 → out_valid at N+2.
  - After reset deassertion, the first instruction is visible 2 cycles later.
  - Redirect at N → target instruction on out_* at N+2.
- Sustained throughput is 1 instruction/cycle with out_ready held high, for DEPTH ≥ 2.
- **Stall**: with out_ready low, the queue fills to exactly DEPTH, counting the in-flight word, then imem_read = 0. Head values are held stable.
- **Reset mid-operation**: all state clears immediately and asynchronously. Any memory word returning after reset is discarded.

## Test plan
- **Reset, then stream.** Setup: RESET_PC = 0x0, memory word k = 0x1000+k, out_ready = 1. Required: out_valid rises 2 cycles after reset release, then (pc, instr) = (0x0, 0x1000), (0x4, 0x1001), … on consecutive cycles with no gaps.
- **Backpressure.** Stimulus: out_ready = 0 for 10 cycles, DEPTH = 4. Required: imem_read issues exactly 4 fetches, then stays 0. Head stays (0x0, 0x1000). On release, 4 entries drain in order with no loss or duplicate.
- **Redirect with in-flight and full queue.** Stimulus: redirect to 0x40 while count = 3 and a fetch is in flight. Required: the stale word is never output, and out_pc = 0x40 two cycles later. A pop asserted in the redirect cycle has no effect.
- **Misaligned redirect.** Stimulus: redirect to 0x42. Required: a single entry appears with out_pc = 0x42 and out_misaligned = 1. imem_read then stays 0 (HALT) until a redirect to 0x80, after which streaming resumes from 0x80.
- **Wrap-around.** Stimulus: redirect to 0xFFFFFFFC. Required: next out_pc values are 0xFFFFFFFC, then 0x00000000. Queue pointers wrap after DEPTH pushes with order preserved.
- **Reset mid-stream.** Stimulus: assert reset while count = 2. Required: out_valid drops to 0 immediately and asynchronously. After release, fetch restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with a registered-address imem port,
// a DEPTH-entry prefetch queue, branch-redirect flush and misaligned-target halt.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic                  imem_read,
  input  logic [XLEN-1:0]       imem_data,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_instruction,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_misaligned
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_next;
  logic [XLEN-1:0] fetch_pc, next_pc, inf_pc;
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic [PW+1:0] occ;
  logic inf_valid, inf_mis, pop, push, issue, mis;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [DEPTH-1:0] q_mis;
  // A redirect flushes first, so its issue credit sees an empty queue and no in-flight word.
  always_comb begin
    next_pc = redirect_valid ? redirect_pc : fetch_pc;
    out_valid = count != '0;
    pop = out_valid & out_ready & ~redirect_valid;
    push = inf_valid & ~redirect_valid;
    occ = redirect_valid ? '0 : {1'b0, count} + (PW+2)'(inf_valid) - (PW+2)'(pop);
    issue = (state == RUN || redirect_valid) && occ < (PW+2)'(DEPTH);
    mis = next_pc[1:0] != 2'b00;
    state_next = issue && mis ? HALT : redirect_valid ? RUN : state;
    imem_read = issue;
    imem_address = next_pc[ADDR_WIDTH+1:2];
    out_instruction = out_valid ? q_instr[head] : '0;
    out_pc = out_valid ? q_pc[head] : '0;
    out_misaligned = out_valid ? q_mis[head] : 1'b0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= RUN;
    else state <= state_next;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
      inf_valid <= 1'b0;
      inf_pc <= '0;
      inf_mis <= 1'b0;
    end else begin
      fetch_pc <= issue ? next_pc + XLEN'(4) : next_pc;
      inf_valid <= issue;
      if (issue) begin
        inf_pc <= next_pc;
        inf_mis <= mis;
      end
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  always_ff @(posedge clock)
    if (push) begin
      q_instr[tail] <= imem_data;
      q_pc[tail] <= inf_pc;
      q_mis[tail] <= inf_mis;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random redirect/backpressure traffic,
// checked every cycle against a queue-level model of the fetch front end.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] imem_address;
  logic imem_read, redirect_valid = 1'b0, out_valid, out_ready = 1'b1, out_misaligned;
  logic [31:0] imem_data = '0, redirect_pc = '0, out_instruction, out_pc;
  typedef struct {logic [31:0] pc; logic mis;} ent_t;
  ent_t mq[$];
  bit m_inf, m_halt;
  logic [31:0] m_inf_pc, m_pc;
  int checks = 0, errors = 0, reads = 0;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .imem_address(imem_address), .imem_read(imem_read),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_misaligned(out_misaligned));

  always #5 clock = ~clock;
  // Memory word at word address k is 0x1000 + k, returned one cycle after the address.
  always @(posedge clock) imem_data <= 32'h1000 + {24'b0, imem_address};

  function automatic logic [31:0] word_of(logic [31:0] pc);
    return 32'h1000 + {24'b0, pc[9:2]};
  endfunction

  function automatic bit m_issue();
    int occ;
    bit pop;
    pop = mq.size() > 0 && out_ready && !redirect_valid;
    occ = redirect_valid ? 0 : mq.size() + int'(m_inf) - int'(pop);
    return (!m_halt || redirect_valid) && occ < DEPTH;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_inf = 0;
    m_halt = 0;
    m_pc = 32'h0;
  endtask

  task automatic compare();
    bit v, iss;
    logic [31:0] np;
    v = mq.size() > 0;
    iss = m_issue();
    np = redirect_valid ? redirect_pc : m_pc;
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("out_pc", out_pc, v ? mq[0].pc : 32'h0);
    chk("out_instruction", out_instruction, v ? word_of(mq[0].pc) : 32'h0);
    chk("out_misaligned", {31'b0, out_misaligned}, {31'b0, v ? mq[0].mis : 1'b0});
    chk("imem_read", {31'b0, imem_read}, {31'b0, iss});
    if (iss) chk("imem_address", {24'b0, imem_address}, {24'b0, np[9:2]});
    if (imem_read) reads++;
  endtask

  task automatic model_edge();
    bit iss, pop;
    logic [31:0] np;
    ent_t e;
    iss = m_issue();
    np = redirect_valid ? redirect_pc : m_pc;
    pop = mq.size() > 0 && out_ready;
    if (redirect_valid) begin
      mq.delete();
      m_inf = 0;
      m_halt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inf) begin
        e.pc = m_inf_pc;
        e.mis = m_inf_pc[1:0] != 2'b00;
        mq.push_back(e);
      end
    end
    m_inf = iss;
    if (iss) begin
      m_inf_pc = np;
      m_halt = m_halt | (np[1:0] != 2'b00);
      m_pc = np + 32'd4;
    end
  endtask

  task automatic step();
    #1 compare();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    m_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    #1 chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_pc", out_pc, 32'd0);
    do_reset(1'b1);
    #1 chk("post-reset imem_read", {31'b0, imem_read}, 32'd1);
    chk("post-reset imem_address", {24'b0, imem_address}, 32'd0);
    step();
    #1 chk("latency out_valid low", {31'b0, out_valid}, 32'd0);
    step();
    #1 chk("stream pc0", out_pc, 32'h0);
    chk("stream instr0", out_instruction, 32'h1000);
    step();
    #1 chk("stream pc1", out_pc, 32'h4);
    chk("stream instr1", out_instruction, 32'h1001);
    repeat (8) step();

    do_reset(1'b0);
    reads = 0;
    repeat (10) step();
    chk("backpressure fetches", reads, 32'd4);
    #1 chk("stall head pc", out_pc, 32'h0);
    chk("stall head instr", out_instruction, 32'h1000);
    out_ready = 1'b1;
    repeat (6) step();

    do_reset(1'b0);
    repeat (4) step();
    out_ready = 1'b1;
    redirect_to(32'h40);
    #1 chk("flush stale", {31'b0, out_valid}, 32'd0);
    step();
    #1 chk("redirect pc", out_pc, 32'h40);
    chk("redirect instr", out_instruction, 32'h1010);
    repeat (4) step();

    redirect_to(32'h42);
    step();
    #1 chk("misaligned pc", out_pc, 32'h42);
    chk("misaligned flag", {31'b0, out_misaligned}, 32'd1);
    chk("misaligned instr", out_instruction, 32'h1010);
    reads = 0;
    repeat (5) step();
    chk("halt no fetch", reads, 32'd0);
    redirect_to(32'h80);
    step();
    #1 chk("resume pc", out_pc, 32'h80);
    step();
    #1 chk("resume pc+4", out_pc, 32'h84);

    redirect_to(32'hFFFF_FFFC);
    step();
    #1 chk("wrap pc top", out_pc, 32'hFFFF_FFFC);
    chk("wrap instr top", out_instruction, 32'h10FF);
    step();
    #1 chk("wrap pc zero", out_pc, 32'h0);
    repeat (10) step();

    out_ready = 1'b0;
    redirect_to(32'h100);
    repeat (2) step();
    #2 reset = 1'b1;
    #1 chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    m_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    #1 chk("restart pc", out_pc, 32'h0);
    chk("restart instr", out_instruction, 32'h1000);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] r;
      out_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      r = $urandom;
      redirect_pc = r[4] ? {22'b0, r[9:2], 2'b00} : r[5] ? (32'hFFFF_FFF0 | {28'b0, r[3:0]}) : {22'b0, r[9:0]};
      step();
    end
    redirect_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
